nasti_lite_write_arbiter: RTL and testbench

NASTI_LITE_WRITE_ARBITER -- requirements
Module: nasti_lite_write_arbiter

---
 rtl/nasti_lite_pkg.sv | 31 +++
 rtl/nasti_lite_write_arbiter_rr.sv | 27 ++
 rtl/nasti_lite_write_arbiter.sv | 143 ++++++++++++++
 tb/tb_nasti_lite_write_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nasti_lite_pkg.sv
// Shared types and helpers for the nasti-lite write arbiter.
package nasti_lite_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Upper bound on requesters; the search helper works on this fixed width.
    localparam int MAX_MASTER = 8;

    // Round-robin find-first: lowest offset from ptr (with wrap) whose req bit is set.
    // Returns {valid, index}. Only the first n request bits take part.
    function automatic logic [3:0] rr_find_first(input logic [MAX_MASTER-1:0] req,
                                                 input logic [2:0]            ptr,
                                                 input int                    n);
        logic [3:0] res;
        int         idx;
        res = '0;
        // Walk offsets high to low so the smallest matching offset wins last.
        for (int k = MAX_MASTER - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = (int'(ptr) + k) % n;
                if (req[idx[2:0]]) res = {1'b1, idx[2:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/nasti_lite_write_arbiter_rr.sv
// Round-robin priority search over the AW valid bits.
module rr_arbiter
    import nasti_lite_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] grant_o,
    output logic          valid_o
);

    logic [MAX_MASTER-1:0] req_pad;
    logic [3:0]            res;

    // Zero-extend the request vector and run the shared search.
    always_comb begin
        req_pad        = '0;
        req_pad[N-1:0] = req_i;
        res            = rr_find_first(req_pad, 3'(ptr_i), N);
    end

    assign grant_o = res[IW-1:0];
    assign valid_o = res[3];

endmodule

// File: rtl/nasti_lite_write_arbiter.sv
// N-to-1 nasti-lite write arbiter: one outstanding transaction, round-robin grant.
module nasti_lite_write_arbiter
    import nasti_lite_pkg::*;
#(
    parameter int N_MASTER        = 2,
    parameter int ID_WIDTH        = 4,
    parameter int ADDR_WIDTH      = 13,
    parameter int LITE_DATA_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [N_MASTER*ID_WIDTH-1:0]        m_aw_id,
    input  logic [N_MASTER*ADDR_WIDTH-1:0]      m_aw_addr,
    input  logic [N_MASTER*3-1:0]               m_aw_prot,
    input  logic [N_MASTER-1:0]                 m_aw_valid,
    output logic [N_MASTER-1:0]                 m_aw_ready,
    input  logic [N_MASTER*LITE_DATA_WIDTH-1:0] m_w_data,
    input  logic [N_MASTER*LITE_DATA_WIDTH/8-1:0] m_w_strb,
    input  logic [N_MASTER-1:0]                 m_w_valid,
    output logic [N_MASTER-1:0]                 m_w_ready,
    output logic [ID_WIDTH-1:0]                 m_b_id,
    output logic [1:0]                          m_b_resp,
    output logic [N_MASTER-1:0]                 m_b_valid,
    input  logic [N_MASTER-1:0]                 m_b_ready,
    output logic [ID_WIDTH-1:0]                 s_aw_id,
    output logic [ADDR_WIDTH-1:0]               s_aw_addr,
    output logic [2:0]                          s_aw_prot,
    output logic                                s_aw_valid,
    input  logic                                s_aw_ready,
    output logic [LITE_DATA_WIDTH-1:0]          s_w_data,
    output logic [LITE_DATA_WIDTH/8-1:0]        s_w_strb,
    output logic                                s_w_valid,
    input  logic                                s_w_ready,
    input  logic [ID_WIDTH-1:0]                 s_b_id,
    input  logic [1:0]                          s_b_resp,
    input  logic                                s_b_valid,
    output logic                                s_b_ready
);

    localparam int GW     = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
    localparam int STRB_W = LITE_DATA_WIDTH / 8;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic [GW-1:0]   arb_grant;
    logic            arb_valid;
    logic            aw_hs, w_hs, b_hs;

    rr_arbiter #(.N(N_MASTER), .IW(GW)) u_rr (
        .req_i   (m_aw_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .valid_o (arb_valid)
    );

    // Route the granted master onto the slave side; gate handshakes by state and done flags.
    always_comb begin
        s_aw_id    = m_aw_id[grant_q*ID_WIDTH +: ID_WIDTH];
        s_aw_addr  = m_aw_addr[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
        s_aw_prot  = m_aw_prot[grant_q*3 +: 3];
        s_w_data   = m_w_data[grant_q*LITE_DATA_WIDTH +: LITE_DATA_WIDTH];
        s_w_strb   = m_w_strb[grant_q*STRB_W +: STRB_W];
        s_aw_valid = 1'b0;
        s_w_valid  = 1'b0;
        s_b_ready  = 1'b0;
        m_aw_ready = '0;
        m_w_ready  = '0;
        m_b_valid  = '0;
        case (state_q)
            ST_ADDR: begin
                s_aw_valid          = m_aw_valid[grant_q] && !aw_done_q;
                m_aw_ready[grant_q] = s_aw_ready && !aw_done_q;
                s_w_valid           = m_w_valid[grant_q] && !w_done_q;
                m_w_ready[grant_q]  = s_w_ready && !w_done_q;
            end
            ST_RESP: begin
                m_b_valid[grant_q] = s_b_valid;
                s_b_ready          = m_b_ready[grant_q];
            end
            default: ;
        endcase
    end

    assign m_b_id   = s_b_id;
    assign m_b_resp = s_b_resp;
    assign aw_hs    = s_aw_valid && s_aw_ready;
    assign w_hs     = s_w_valid && s_w_ready;
    assign b_hs     = s_b_valid && s_b_ready;

    // Next-state: grant in IDLE, wait for both AW and W in ADDR, release on B.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_grant;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (b_hs) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (grant_q == GW'(N_MASTER - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_nasti_lite_write_arbiter.sv
// Directed bench: cycle table for the 2-master arbiter plus hand sequences for stalls, reset and wrap.
module tb_nasti_lite_write_arbiter;
    import nasti_lite_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---------------- 2-master instance ----------------
    logic [7:0]  n2_maw_id;
    logic [25:0] n2_maw_addr;
    logic [5:0]  n2_maw_prot;
    logic [1:0]  n2_maw_valid, n2_maw_ready;
    logic [63:0] n2_mw_data;
    logic [7:0]  n2_mw_strb;
    logic [1:0]  n2_mw_valid, n2_mw_ready;
    logic [3:0]  n2_mb_id;
    logic [1:0]  n2_mb_resp, n2_mb_valid, n2_mb_ready;
    logic [3:0]  n2_saw_id;
    logic [12:0] n2_saw_addr;
    logic [2:0]  n2_saw_prot;
    logic        n2_saw_valid, n2_saw_ready;
    logic [31:0] n2_sw_data;
    logic [3:0]  n2_sw_strb;
    logic        n2_sw_valid, n2_sw_ready;
    logic [3:0]  n2_sb_id;
    logic [1:0]  n2_sb_resp;
    logic        n2_sb_valid, n2_sb_ready;

    nasti_lite_write_arbiter #(.N_MASTER(2)) u2 (
        .clk(clk), .rstn(rstn),
        .m_aw_id(n2_maw_id), .m_aw_addr(n2_maw_addr), .m_aw_prot(n2_maw_prot),
        .m_aw_valid(n2_maw_valid), .m_aw_ready(n2_maw_ready),
        .m_w_data(n2_mw_data), .m_w_strb(n2_mw_strb),
        .m_w_valid(n2_mw_valid), .m_w_ready(n2_mw_ready),
        .m_b_id(n2_mb_id), .m_b_resp(n2_mb_resp),
        .m_b_valid(n2_mb_valid), .m_b_ready(n2_mb_ready),
        .s_aw_id(n2_saw_id), .s_aw_addr(n2_saw_addr), .s_aw_prot(n2_saw_prot),
        .s_aw_valid(n2_saw_valid), .s_aw_ready(n2_saw_ready),
        .s_w_data(n2_sw_data), .s_w_strb(n2_sw_strb),
        .s_w_valid(n2_sw_valid), .s_w_ready(n2_sw_ready),
        .s_b_id(n2_sb_id), .s_b_resp(n2_sb_resp),
        .s_b_valid(n2_sb_valid), .s_b_ready(n2_sb_ready)
    );

    // ---------------- 3-master instance ----------------
    logic [11:0] n3_maw_id;
    logic [38:0] n3_maw_addr;
    logic [8:0]  n3_maw_prot;
    logic [2:0]  n3_maw_valid, n3_maw_ready;
    logic [95:0] n3_mw_data;
    logic [11:0] n3_mw_strb;
    logic [2:0]  n3_mw_valid, n3_mw_ready;
    logic [3:0]  n3_mb_id;
    logic [1:0]  n3_mb_resp;
    logic [2:0]  n3_mb_valid, n3_mb_ready;
    logic [3:0]  n3_saw_id;
    logic [12:0] n3_saw_addr;
    logic [2:0]  n3_saw_prot;
    logic        n3_saw_valid, n3_saw_ready;
    logic [31:0] n3_sw_data;
    logic [3:0]  n3_sw_strb;
    logic        n3_sw_valid, n3_sw_ready;
    logic [3:0]  n3_sb_id;
    logic [1:0]  n3_sb_resp;
    logic        n3_sb_valid, n3_sb_ready;

    nasti_lite_write_arbiter #(.N_MASTER(3)) u3 (
        .clk(clk), .rstn(rstn),
        .m_aw_id(n3_maw_id), .m_aw_addr(n3_maw_addr), .m_aw_prot(n3_maw_prot),
        .m_aw_valid(n3_maw_valid), .m_aw_ready(n3_maw_ready),
        .m_w_data(n3_mw_data), .m_w_strb(n3_mw_strb),
        .m_w_valid(n3_mw_valid), .m_w_ready(n3_mw_ready),
        .m_b_id(n3_mb_id), .m_b_resp(n3_mb_resp),
        .m_b_valid(n3_mb_valid), .m_b_ready(n3_mb_ready),
        .s_aw_id(n3_saw_id), .s_aw_addr(n3_saw_addr), .s_aw_prot(n3_saw_prot),
        .s_aw_valid(n3_saw_valid), .s_aw_ready(n3_saw_ready),
        .s_w_data(n3_sw_data), .s_w_strb(n3_sw_strb),
        .s_w_valid(n3_sw_valid), .s_w_ready(n3_sw_ready),
        .s_b_id(n3_sb_id), .s_b_resp(n3_sb_resp),
        .s_b_valid(n3_sb_valid), .s_b_ready(n3_sb_ready)
    );

    // One table row = inputs for one cycle plus the outputs expected in that cycle.
    // exp = {s_aw_valid, s_w_valid, m_aw_ready[1:0], m_w_ready[1:0], m_b_valid[1:0], s_b_ready}
    typedef struct {
        logic [1:0]  awv;
        logic [1:0]  wv;
        logic        saw_rdy;
        logic        sw_rdy;
        logic        sbv;
        logic [1:0]  bresp;
        logic [1:0]  bready;
        logic [8:0]  exp;
        logic [1:0]  exp_resp;
        logic [12:0] exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: no response within cycle budget", name);
    endtask

    // Run one 2-master transaction with an always-ready slave; check who is granted.
    task automatic n2_txn(input logic [1:0] req, input int exp_g, input string name);
        bit seen = 0;
        bit done = 0;
        n2_maw_valid = req; n2_mw_valid = req;
        n2_saw_ready = 1'b1; n2_sw_ready = 1'b1;
        n2_sb_valid  = 1'b1; n2_sb_resp  = 2'b00; n2_mb_ready = 2'b11;
        for (int c = 0; c < 12 && !done; c++) begin
            #1;
            if (n2_saw_valid && !seen) begin
                chk({name, " aw_grant"}, 64'(n2_maw_ready), 64'(2'b01 << exp_g));
                seen = 1;
            end
            if (n2_sb_ready) begin
                chk({name, " b_valid"}, 64'(n2_mb_valid), 64'(2'b01 << exp_g));
                done = 1;
            end
            @(negedge clk);
        end
        if (!done) timeout(name);
    endtask

    task automatic n3_txn(input logic [2:0] req, input int exp_g, input string name);
        bit seen = 0;
        bit done = 0;
        n3_maw_valid = req; n3_mw_valid = req;
        n3_saw_ready = 1'b1; n3_sw_ready = 1'b1;
        n3_sb_valid  = 1'b1; n3_sb_resp  = 2'b00; n3_mb_ready = 3'b111;
        for (int c = 0; c < 12 && !done; c++) begin
            #1;
            if (n3_saw_valid && !seen) begin
                chk({name, " aw_grant"}, 64'(n3_maw_ready), 64'(3'b001 << exp_g));
                seen = 1;
            end
            if (n3_sb_ready) begin
                chk({name, " b_valid"}, 64'(n3_mb_valid), 64'(3'b001 << exp_g));
                done = 1;
            end
            @(negedge clk);
        end
        if (!done) timeout(name);
    endtask

    initial begin
        // Per-master static fields: m0 @0x010/DEADBEEF, m1 @0x020/12345678.
        n2_maw_id   = {4'h2, 4'h1};
        n2_maw_addr = {13'h020, 13'h010};
        n2_maw_prot = {3'h5, 3'h2};
        n2_mw_data  = {32'h12345678, 32'hDEADBEEF};
        n2_mw_strb  = {4'h3, 4'hF};
        n2_sb_id    = 4'h5;
        n3_maw_id   = {4'h3, 4'h2, 4'h1};
        n3_maw_addr = {13'h030, 13'h020, 13'h010};
        n3_maw_prot = '0;
        n3_mw_data  = {32'h33333333, 32'h22222222, 32'h11111111};
        n3_mw_strb  = '1;
        n3_sb_id    = 4'h0;

        //           awv    wv     sawr  swr   sbv   resp   bready exp            eresp  addr     data
        tbl[0]  = '{2'b01, 2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 9'b0_0_00_00_00_0, 2'b00, 13'h0,   32'h0};
        tbl[1]  = '{2'b01, 2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 9'b1_1_01_01_00_0, 2'b00, 13'h010, 32'hDEADBEEF};
        tbl[2]  = '{2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 2'b00, 2'b01, 9'b0_0_00_00_01_1, 2'b00, 13'h0,   32'h0};
        tbl[3]  = '{2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 9'b0_0_00_00_00_0, 2'b00, 13'h0,   32'h0};
        tbl[4]  = '{2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 9'b0_0_00_00_00_0, 2'b00, 13'h0,   32'h0};
        tbl[5]  = '{2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 9'b1_1_10_10_00_0, 2'b00, 13'h020, 32'h12345678};
        tbl[6]  = '{2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 2'b10, 2'b00, 9'b0_0_00_00_10_0, 2'b10, 13'h0,   32'h0};
        tbl[7]  = '{2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 2'b10, 2'b00, 9'b0_0_00_00_10_0, 2'b10, 13'h0,   32'h0};
        tbl[8]  = '{2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 2'b10, 2'b10, 9'b0_0_00_00_10_1, 2'b10, 13'h0,   32'h0};
        tbl[9]  = '{2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 2'b10, 2'b11, 9'b0_0_00_00_00_0, 2'b10, 13'h0,   32'h0};
        tbl[10] = '{2'b00, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 9'b0_0_00_00_00_0, 2'b00, 13'h0,   32'h0};
        tbl[11] = '{2'b00, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 9'b0_0_00_00_00_0, 2'b00, 13'h0,   32'h0};

        // Reset with every input asserted: nothing may leak out.
        rstn = 1'b0;
        n2_maw_valid = 2'b11; n2_mw_valid = 2'b11; n2_mb_ready = 2'b11;
        n2_saw_ready = 1'b1;  n2_sw_ready = 1'b1;  n2_sb_valid = 1'b1; n2_sb_resp = 2'b00;
        n3_maw_valid = 3'b000; n3_mw_valid = 3'b000; n3_mb_ready = 3'b000;
        n3_saw_ready = 1'b0;  n3_sw_ready = 1'b0;  n3_sb_valid = 1'b0; n3_sb_resp = 2'b00;
        @(negedge clk); @(negedge clk); #1;
        chk("rst ctl", 64'({n2_saw_valid, n2_sw_valid, n2_maw_ready, n2_mw_ready, n2_mb_valid, n2_sb_ready}), 64'h0);
        chk("rst state", 64'(u2.state_q), 64'(ST_IDLE));
        chk("rst rr_ptr", 64'(u2.rr_ptr_q), 64'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Table: single write from m0, SLVERR to m1 with stalled m_b_ready, B in IDLE, W-only request.
        for (int i = 0; i < 12; i++) begin
            n2_maw_valid = tbl[i].awv;   n2_mw_valid = tbl[i].wv;
            n2_saw_ready = tbl[i].saw_rdy; n2_sw_ready = tbl[i].sw_rdy;
            n2_sb_valid  = tbl[i].sbv;   n2_sb_resp  = tbl[i].bresp;
            n2_mb_ready  = tbl[i].bready;
            #1;
            chk($sformatf("row%0d ctl", i),
                64'({n2_saw_valid, n2_sw_valid, n2_maw_ready, n2_mw_ready, n2_mb_valid, n2_sb_ready}),
                64'(tbl[i].exp));
            chk($sformatf("row%0d b_resp", i), 64'(n2_mb_resp), 64'(tbl[i].exp_resp));
            if (tbl[i].exp[8]) begin
                chk($sformatf("row%0d aw_addr", i), 64'(n2_saw_addr), 64'(tbl[i].exp_addr));
                chk($sformatf("row%0d w_data", i), 64'(n2_sw_data), 64'(tbl[i].exp_data));
            end
            @(negedge clk);
        end
        chk("b_id bcast", 64'(n2_mb_id), 64'h5);
        n2_mw_valid = 2'b00; n2_sb_valid = 1'b0;

        // Both masters requesting continuously: strict alternation.
        n2_txn(2'b11, 0, "rr0");
        n2_txn(2'b11, 1, "rr1");
        n2_txn(2'b11, 0, "rr2");
        n2_txn(2'b11, 1, "rr3");
        n2_maw_valid = 2'b00; n2_mw_valid = 2'b00; n2_sb_valid = 1'b0;
        @(negedge clk);

        // W stalled 3 cycles after AW handshake; m0 keeps m_aw_valid high throughout.
        n2_maw_valid = 2'b01; n2_mw_valid = 2'b01;
        n2_saw_ready = 1'b1;  n2_sw_ready = 1'b0; n2_sb_valid = 1'b0; n2_mb_ready = 2'b00;
        @(negedge clk); #1;
        chk("wstall aw_hs", 64'({n2_saw_valid, n2_maw_ready}), 64'({1'b1, 2'b01}));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk($sformatf("wstall c%0d aw_valid", c), 64'(n2_saw_valid), 64'h0);
            chk($sformatf("wstall c%0d w_valid", c), 64'(n2_sw_valid), 64'h1);
            chk($sformatf("wstall c%0d state", c), 64'(u2.state_q), 64'(ST_ADDR));
        end
        @(negedge clk);
        n2_sw_ready = 1'b1;
        #1;
        chk("wstall w_hs", 64'({n2_sw_valid, n2_mw_ready}), 64'({1'b1, 2'b01}));
        @(negedge clk);
        n2_maw_valid = 2'b00; n2_mw_valid = 2'b00;
        n2_sb_valid = 1'b1; n2_mb_ready = 2'b01;
        #1;
        chk("wstall resp state", 64'(u2.state_q), 64'(ST_RESP));
        chk("wstall b", 64'({n2_mb_valid, n2_sb_ready}), 64'({2'b01, 1'b1}));
        @(negedge clk);
        n2_sb_valid = 1'b0;

        // Reset during RESP of an m1 write (rr_ptr is 1 here); afterwards arbitration restarts at 0.
        n2_maw_valid = 2'b10; n2_mw_valid = 2'b10; n2_mb_ready = 2'b00;
        @(negedge clk); @(negedge clk);
        n2_maw_valid = 2'b00; n2_mw_valid = 2'b00;
        #1;
        chk("rstmid resp", 64'(u2.state_q), 64'(ST_RESP));
        rstn = 1'b0;
        n2_sb_valid = 1'b1; n2_mb_ready = 2'b11;
        #1;
        chk("rstmid ctl", 64'({n2_saw_valid, n2_sw_valid, n2_maw_ready, n2_mw_ready, n2_mb_valid, n2_sb_ready}), 64'h0);
        chk("rstmid state", 64'(u2.state_q), 64'(ST_IDLE));
        @(negedge clk);
        rstn = 1'b1;
        n2_txn(2'b11, 0, "post_rst");
        n2_maw_valid = 2'b00; n2_mw_valid = 2'b00; n2_sb_valid = 1'b0;

        // Three masters: m2 alone, then m0+m2 (pointer wraps to 0), then m0+m2 again.
        n3_txn(3'b100, 2, "n3_a");
        n3_txn(3'b101, 0, "n3_b");
        n3_txn(3'b101, 2, "n3_c");
        n3_maw_valid = 3'b000; n3_mw_valid = 3'b000; n3_sb_valid = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
